// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two prioritised write
// ports, hardwired-zero register 0, per-register pending scoreboard and a
// sequential clear engine that zeroes one entry per cycle.
//
// Optional build macro: REGFILE_MP_BYPASS_EN
//    defined   -> write-first forwarding from the write ports to the read ports
//    undefined -> reads return the pre-edge register contents
//
// state  | meaning
// -------+---------------------------------------------------------------
// CLEAR  | clear engine walks clr_cnt over all entries; ports blocked
// IDLE   | normal operation: reads, writes, scoreboard updates

module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pend,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     clear_req,
   output logic                     busy
);

   localparam logic [0:0]        ST_IDLE  = 1'b0;
   localparam logic [0:0]        ST_CLEAR = 1'b1;
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  sb;
   logic              wr0_go;
   logic              wr1_go;

   assign busy = (state == ST_CLEAR);

   // A write commits only outside a clear and never to register 0.
   assign wr0_go = wr0_en && !busy && (wr0_addr != '0);
   assign wr1_go = wr1_en && !busy && (wr1_addr != '0);

   // Clear sequencer: reset or clear_req starts a walk over every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + ADDR_W'(1);
         if (clr_cnt == LAST) state <= ST_IDLE;
      end else if (clear_req) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end
   end

   // Register storage: clear engine zeroes one entry per cycle, otherwise
   // port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            if (clr_cnt != '0) mem[clr_cnt] <= '0;
         end else begin
            if (wr0_go) mem[wr0_addr] <= wr0_data;
            if (wr1_go) mem[wr1_addr] <= wr1_data;
         end
      end
   end

   // Pending scoreboard: writes retire a producer, a same-cycle sb_set wins
   // because it represents a newer producer.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb <= '0;
      end else if (busy) begin
         sb[clr_cnt] <= 1'b0;
      end else begin
         if (wr0_go) sb[wr0_addr] <= 1'b0;
         if (wr1_go) sb[wr1_addr] <= 1'b0;
         if (sb_set && (sb_addr != '0)) sb[sb_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              p;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];

      // Combinational read; register 0 and the clear window read as zero.
      always_comb begin
         d = '0;
         p = 1'b0;
         if (!busy && (ra != '0)) begin
`ifdef REGFILE_MP_BYPASS_EN
            if (wr1_go && (wr1_addr == ra)) begin
               d = wr1_data;
            end else if (wr0_go && (wr0_addr == ra)) begin
               d = wr0_data;
            end else begin
               d = mem[ra];
               p = sb[ra];
            end
`else
            d = mem[ra];
            p = sb[ra];
`endif
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = d;
      assign rd_pend[i]                  = p;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed test-plan steps followed by a
// randomised phase, all checked against an array-based reference model.

module tb_regfile_mp;

   localparam int DW = 32;
   localparam int DP = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_pend;
   logic             wr0_en, wr1_en, sb_set, clear_req, busy;
   logic [AW-1:0]    wr0_addr, wr1_addr, sb_addr;
   logic [DW-1:0]    wr0_data, wr1_data;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] m_mem [DP];
   bit            m_pend [DP];
   int            busy_left;

   regfile_mp #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_pend(rd_pend), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
      .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
      .wr1_data(wr1_data), .sb_set(sb_set), .sb_addr(sb_addr),
      .clear_req(clear_req), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected outputs from the model and the inputs currently applied.
   task automatic check_outputs(input string tag);
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      logic          ep;
      chk({tag, "_busy"}, 64'(busy), 64'(busy_left > 0));
      for (int p = 0; p < NR; p++) begin
         a  = rd_addr[p*AW +: AW];
         ed = '0;
         ep = 1'b0;
         if (busy_left == 0 && a != 0) begin
            ed = m_mem[a];
            ep = m_pend[a];
`ifdef REGFILE_MP_BYPASS_EN
            if (wr1_en && wr1_addr == a) begin
               ed = wr1_data; ep = 1'b0;
            end else if (wr0_en && wr0_addr == a) begin
               ed = wr0_data; ep = 1'b0;
            end
`endif
         end
         chk({tag, "_data"}, 64'(rd_data[p*DW +: DW]), 64'(ed));
         chk({tag, "_pend"}, 64'(rd_pend[p]), 64'(ep));
      end
   endtask

   // Advance the model by one clock edge, then wait for the DUT edge.
   task automatic tick();
      if (reset) begin
         busy_left = DP;
         for (int r = 0; r < DP; r++) m_pend[r] = 0;
      end else if (busy_left > 0) begin
         if (DP - busy_left != 0) m_mem[DP - busy_left] = '0;
         m_pend[DP - busy_left] = 0;
         busy_left--;
      end else begin
         if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 0; end
         if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 0; end
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1;
         if (clear_req) busy_left = DP;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag);
      #3;
      check_outputs(tag);
      tick();
   endtask

   task automatic idle_inputs();
      reset = 0; wr0_en = 0; wr1_en = 0; sb_set = 0; clear_req = 0;
      wr0_addr = '0; wr1_addr = '0; sb_addr = '0; wr0_data = '0; wr1_data = '0;
   endtask

   initial begin
      int n;
      for (int r = 0; r < DP; r++) begin m_mem[r] = '0; m_pend[r] = 0; end
      busy_left = 0;
      idle_inputs();
      rd_addr = '0;
      reset = 1;
      @(posedge clk); #1;
      tick();
      reset = 0;

      // busy window after reset
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc("rst_clr"); n++; end
      chk("rst_busy_len", 64'(n), 64'd32);

      // every register reads zero on both ports
      for (int a = 0; a < DP; a++) begin
         rd_addr = {AW'(DP - 1 - a), AW'(a)};
         #2;
         chk("sweep_zero", 64'(rd_data), 64'd0);
         cyc("sweep");
      end

      // two writes to distinct registers
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
      wr1_en = 1; wr1_addr = 9; wr1_data = 32'h12345678;
      cyc("dual_wr");
      idle_inputs();
      rd_addr = {5'd9, 5'd5};
      #1;
      chk("dual_rd", 64'(rd_data), {32'h12345678, 32'hDEADBEEF});
      cyc("dual_rd_m");

      // same-address collision and r0 write
      wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1111;
      wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2222;
      cyc("coll_wr");
      idle_inputs();
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
      cyc("r0_wr");
      idle_inputs();
      rd_addr = {5'd0, 5'd7};
      #1;
      chk("coll_r0", 64'(rd_data), {32'h0, 32'h2222});
      cyc("coll_r0_m");

      // scoreboard set / clear / set-wins
      sb_set = 1; sb_addr = 3;
      cyc("sb_set3");
      idle_inputs();
      rd_addr = {5'd0, 5'd3};
      #1;
      chk("sb_pend3", 64'(rd_pend), 64'b01);
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'h33;
      cyc("sb_wr3");
      idle_inputs();
      #1;
      chk("sb_clr3", 64'(rd_pend), 64'b00);
      sb_set = 1; sb_addr = 4; wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44;
      cyc("sb_setwin");
      idle_inputs();
      rd_addr = {5'd4, 5'd0};
      #1;
      chk("sb_pend4", 64'(rd_pend), 64'b10);
      cyc("sb_pend4_m");

      // forwarding behaviour
      wr0_en = 1; wr0_addr = 6; wr0_data = 32'h1;
      cyc("byp_pre");
      wr0_data = 32'hA5A5A5A5;
      rd_addr = {5'd0, 5'd6};
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      chk("byp_same", 64'(rd_data[31:0]), 64'hA5A5A5A5);
`else
      chk("byp_same", 64'(rd_data[31:0]), 64'h1);
`endif
      cyc("byp_wr");
      idle_inputs();
      #1;
      chk("byp_next", 64'(rd_data[31:0]), 64'hA5A5A5A5);
      cyc("byp_next_m");

      // clear_req with writes dropped during the window
      wr0_en = 1; wr0_addr = 10; wr0_data = 32'h55;
      cyc("clr_pre");
      idle_inputs();
      clear_req = 1;
      cyc("clr_req");
      clear_req = 0;
      wr0_en = 1; wr0_addr = 10; wr0_data = 32'h77; sb_set = 1; sb_addr = 10;
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc("clr_win"); n++; end
      chk("clr_busy_len", 64'(n), 64'd32);
      idle_inputs();
      rd_addr = {5'd10, 5'd10};
      #1;
      chk("clr_r10", 64'(rd_data), 64'd0);
      chk("clr_r10_pend", 64'(rd_pend), 64'd0);
      cyc("clr_after");

      // reset in the middle of a clear restarts the walk
      clear_req = 1;
      cyc("rc_req");
      clear_req = 0;
      for (int i = 0; i < 10; i++) cyc("rc_mid");
      reset = 1;
      cyc("rc_rst");
      reset = 0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin cyc("rc_win"); n++; end
      chk("rc_busy_len", 64'(n), 64'd32);

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         rd_addr   = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
         wr0_en    = 1'($urandom_range(0, 1));
         wr1_en    = 1'($urandom_range(0, 1));
         wr0_addr  = AW'($urandom_range(0, 15));
         wr1_addr  = AW'($urandom_range(0, 15));
         wr0_data  = $urandom;
         wr1_data  = $urandom;
         sb_set    = 1'($urandom_range(0, 1));
         sb_addr   = AW'($urandom_range(0, 15));
         clear_req = ($urandom_range(0, 79) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
